// File: rtl/muskbus_writer.sv
// muskbus_writer: write-side Muskbus master. It accepts one 64-byte line from
// a client and sends it as one address beat followed by eight 64-bit data
// beats. Each beat is held until bus_reqack, and a one-cycle wr_done pulse
// marks completion.
// Optional feature macro: MUSKBUS_WRITER_ACK_EN. When it is defined, the
// writer waits in WAIT_RESP for a tagged write response before completing.

module muskbus_writer #(
    parameter logic [4:0] TAG_TYPE = 5'b00001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_reqcyc,
    input  logic [63:0]  wr_addr,
    input  logic [0:511] wr_data,
    output logic         wr_busy,
    output logic         wr_done,
    output logic         bus_reqcyc,
    output logic [63:0]  bus_req,
    output logic [13:0]  bus_reqtag,
    input  logic         bus_reqack,
    input  logic         bus_respcyc,
    input  logic [13:0]  bus_resptag,
    output logic         bus_respack
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
`ifdef MUSKBUS_WRITER_ACK_EN
        DATA      = 2'd2,
        WAIT_RESP = 2'd3
`else
        DATA      = 2'd2
`endif
    } state_t;

    state_t         state;
    logic [2:0]     beat;
    logic [2:0]     next_beat;
    logic [7:0]     id_q;
    logic [13:0]    issued_tag;
    logic [0:511]   data_q;
    logic           unused_inputs;

    assign next_beat  = beat + 3'd1;
    assign issued_tag = {1'b1, TAG_TYPE, id_q};

`ifdef MUSKBUS_WRITER_ACK_EN
    // The response handshake completes in the cycle the matching response is
    // present. It is gated by WAIT_RESP, so bus_reqack never reaches it.
    assign bus_respack   = (state == WAIT_RESP) && bus_respcyc && (bus_resptag == issued_tag);
    assign unused_inputs = ^wr_addr[5:0];
`else
    assign bus_respack   = 1'b0;
    assign unused_inputs = ^{wr_addr[5:0], bus_respcyc, bus_resptag};
`endif

    // Capture the line payload on acceptance. It stays frozen while busy.
    // NOTE: this wide capture register has no reset. It is always written on
    // acceptance before any beat reads it, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_reqcyc) begin
            data_q <= wr_data;
        end
    end

    // Transfer FSM with registered bus and client-side outputs.
    // NOTE: all sequential state uses non-blocking (<=), so every register
    // samples pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat       <= 3'd0;
            id_q       <= 8'd0;
            bus_reqcyc <= 1'b0;
            bus_req    <= 64'd0;
            bus_reqtag <= 14'd0;
            wr_busy    <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_reqcyc) begin
                        state      <= ADDR;
                        wr_busy    <= 1'b1;
                        bus_reqcyc <= 1'b1;
                        bus_req    <= {wr_addr[63:6], 6'b0};
                        bus_reqtag <= issued_tag;
                    end
                end
                ADDR: begin
                    if (bus_reqack) begin
                        state   <= DATA;
                        beat    <= 3'd0;
                        bus_req <= data_q[0:63];
                    end
                end
                DATA: begin
                    if (bus_reqack) begin
                        if (beat == 3'd7) begin
                            bus_reqcyc <= 1'b0;
                            bus_req    <= 64'd0;
                            bus_reqtag <= 14'd0;
`ifdef MUSKBUS_WRITER_ACK_EN
                            state      <= WAIT_RESP;
`else
                            state      <= IDLE;
                            wr_busy    <= 1'b0;
                            wr_done    <= 1'b1;
                            id_q       <= id_q + 8'd1;
`endif
                        end else begin
                            beat    <= next_beat;
                            bus_req <= data_q[{next_beat, 6'd0} +: 64];
                        end
                    end
                end
`ifdef MUSKBUS_WRITER_ACK_EN
                WAIT_RESP: begin
                    if (bus_respack) begin
                        state   <= IDLE;
                        wr_busy <= 1'b0;
                        wr_done <= 1'b1;
                        id_q    <= id_q + 8'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muskbus_writer.sv
// Self-checking bench for muskbus_writer. It runs a table of directed lines,
// hand-written freeze and reset corner cases, and randomized lines. All of
// these are checked against a beat-queue reference model built from the
// line's bytes.
// Optional feature macro: MUSKBUS_WRITER_ACK_EN (response handshake).

module tb_muskbus_writer;

    logic         clk;
    logic         reset;
    logic         wr_reqcyc;
    logic [63:0]  wr_addr;
    logic [0:511] wr_data;
    logic         wr_busy;
    logic         wr_done;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [13:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [13:0]  bus_resptag;
    logic         bus_respack;

    muskbus_writer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_reqcyc   (wr_reqcyc),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_busy     (wr_busy),
        .wr_done     (wr_done),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  line_bytes [64];
    int          stall_before [9];   // index 0 = address beat, k+1 = data beat k
    logic [63:0] seen_beat [8];
    int          model_id = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] exp_addr;
        int          s_addr;
        int          s_b4;
        bit          hold;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus word k holds bytes 8k..8k+7, with the lowest-numbered byte in the top bits.
    function automatic logic [63:0] word_of(input int k);
        logic [63:0] w;
        w = 64'd0;
        for (int b = 0; b < 8; b++) w = (w << 8) | 64'(line_bytes[8 * k + b]);
        return w;
    endfunction

    task automatic pack_line();
        for (int i = 0; i < 64; i++) wr_data[i * 8 +: 8] = line_bytes[i];
    endtask

    // Issue one line and check every presented beat against the expected
    // queue. The bench drives the acks, so the loop is bounded by construction.
    task automatic run_line(input logic [63:0] addr, input logic [63:0] exp_addr,
                            input bit hold, input int corrupt_at, output int latency);
        logic [63:0] exp_q [$];
        logic [13:0] exp_tag;
        int          edges;
        int          stall;
        int          j;
        exp_q = {};
        exp_q.push_back(exp_addr);
        for (int k = 0; k < 8; k++) exp_q.push_back(word_of(k));
        exp_tag = 14'h2100 + 14'(model_id);
        pack_line();
        wr_addr   = addr;
        wr_reqcyc = 1'b1;
        tick();
        edges = 1;
        if (!hold) wr_reqcyc = 1'b0;
        j = 0;
        stall = stall_before[0];
        while (exp_q.size() > 0 && edges < 1000) begin
            check("beat_reqcyc", bus_reqcyc, 1);
            check("beat_value", bus_req, exp_q[0]);
            check("beat_tag", bus_reqtag, exp_tag);
            check("beat_busy", wr_busy, 1);
            check("beat_done", wr_done, 0);
            check("beat_respack", bus_respack, 0);
            if (j >= 1) seen_beat[j - 1] = bus_req;
            if (j == corrupt_at) begin
                wr_data = '1;
                wr_addr = {$urandom, $urandom};
            end
            bus_respcyc = 1'($urandom_range(0, 1));
            bus_resptag = exp_tag;
            if (stall > 0) begin
                bus_reqack = 1'b0;
                stall--;
            end else begin
                bus_reqack = 1'b1;
                void'(exp_q.pop_front());
                j++;
                if (j < 9) stall = stall_before[j];
            end
            tick();
            edges++;
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b1;
`ifdef MUSKBUS_WRITER_ACK_EN
        check("wait_reqcyc", bus_reqcyc, 0);
        check("wait_busy", wr_busy, 1);
        bus_respcyc = 1'b1;
        bus_resptag = exp_tag ^ 14'h0005;
        #1;
        check("resp_wrong_tag", bus_respack, 0);
        tick();
        edges++;
        check("no_done_wrong_tag", wr_done, 0);
        bus_resptag = exp_tag;
        #1;
        check("resp_match", bus_respack, 1);
        tick();
        edges++;
        bus_respcyc = 1'b0;
        edges = edges - 2;
`endif
        check("done_pulse", wr_done, 1);
        check("done_busy_low", wr_busy, 0);
        check("done_bus_idle", bus_reqcyc, 0);
        latency  = edges;
        model_id = (model_id + 1) % 256;
        if (!hold) begin
            tick();
            check("done_one_cycle", wr_done, 0);
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   lat;
        int   sum;
        bit   hold;
        logic [63:0] a;

        vecs[0] = '{64'h0000_0000_1000_0047, 64'h0000_0000_1000_0040, 0, 0, 1'b1, 10};
        vecs[1] = '{64'h2000_0000_0000_1234, 64'h2000_0000_0000_1200, 3, 2, 1'b0, 15};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 1, 0, 1'b0, 11};
        vecs[3] = '{64'h0000_0000_0000_003F, 64'h0000_0000_0000_0000, 0, 5, 1'b0, 15};

        // Reset held with a pending request: all outputs must stay quiet.
        reset       = 1'b0;
        wr_reqcyc   = 1'b1;
        wr_addr     = 64'h0000_0000_1000_0047;
        wr_data     = '0;
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b0;
        bus_resptag = 14'd0;
        repeat (3) tick();
        check("rst_reqcyc", bus_reqcyc, 0);
        check("rst_req", bus_req, 0);
        check("rst_tag", bus_reqtag, 0);
        check("rst_respack", bus_respack, 0);
        check("rst_busy", wr_busy, 0);
        check("rst_done", wr_done, 0);
        reset = 1'b1;

        // Directed table: the first two entries run back to back (tags 2100, 2101).
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 64; i++) line_bytes[i] = 8'(i + 17 * v);
            for (int s = 0; s < 9; s++) stall_before[s] = 0;
            stall_before[0] = vecs[v].s_addr;
            stall_before[5] = vecs[v].s_b4;
            run_line(vecs[v].addr, vecs[v].exp_addr, vecs[v].hold, -1, lat);
            check("vec_latency", lat, vecs[v].exp_lat);
            if (v == 0) begin
                check("vec0_first_word", seen_beat[0], 64'h0001_0203_0405_0607);
                check("vec0_last_word", seen_beat[7], 64'h3839_3A3B_3C3D_3E3F);
            end
        end

        // Input freeze: wr_data/wr_addr are trashed from data beat 3 onward.
        for (int i = 0; i < 64; i++) line_bytes[i] = 8'(255 - i);
        for (int s = 0; s < 9; s++) stall_before[s] = 0;
        stall_before[6] = 2;
        run_line(64'h0000_0003_0000_0100, 64'h0000_0003_0000_0100, 1'b0, 4, lat);
        check("freeze_latency", lat, 12);

        // Reset during data beat 3: bus drops at once, no done, and the id restarts at 0.
        for (int i = 0; i < 64; i++) line_bytes[i] = 8'(3 * i + 1);
        pack_line();
        wr_addr   = 64'h0000_0000_4000_0080;
        wr_reqcyc = 1'b1;
        bus_reqack = 1'b1;
        tick();
        wr_reqcyc = 1'b0;
        repeat (4) tick();
        check("mid_beat3", bus_req, word_of(3));
        reset = 1'b0;
        #1;
        check("mid_rst_reqcyc", bus_reqcyc, 0);
        check("mid_rst_busy", wr_busy, 0);
        check("mid_rst_done", wr_done, 0);
        repeat (2) tick();
        reset    = 1'b1;
        model_id = 0;
        repeat (3) begin
            tick();
            check("post_rst_no_done", wr_done, 0);
            check("post_rst_idle", bus_reqcyc, 0);
        end
        for (int s = 0; s < 9; s++) stall_before[s] = 0;
        run_line(64'h0000_0000_4000_00C0, 64'h0000_0000_4000_00C0, 1'b0, -1, lat);
        check("post_rst_latency", lat, 10);

        // Randomized lines: random data, address, stalls, freezes, and back-to-back
        // requests. There are enough lines to wrap the 8-bit id (255 -> 0).
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 64; i++) line_bytes[i] = 8'($urandom);
            sum = 0;
            for (int s = 0; s < 9; s++) begin
                stall_before[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                sum += stall_before[s];
            end
            a    = {$urandom, $urandom};
            hold = 1'($urandom_range(0, 1));
            run_line(a, a & ~64'h3F, hold, int'($urandom_range(0, 12)), lat);
            check("rand_latency", lat, 10 + sum);
        end
        wr_reqcyc = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
